// File: rtl/fmt_receiver_if.sv
// Formatter-side packet bus and downstream word stream of fmt_receiver.
interface fmt_receiver_if;
    logic        fmt_req_i;
    logic        fmt_grant_o;
    logic [1:0]  fmt_chid_i;
    logic [5:0]  fmt_length_i;
    logic [31:0] fmt_data_i;
    logic        fmt_start_i;
    logic        fmt_end_i;
    logic [31:0] out_data_o;
    logic [1:0]  out_chid_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;

    modport slave (
        input  fmt_req_i, fmt_chid_i, fmt_length_i, fmt_data_i, fmt_start_i, fmt_end_i, out_ready_i,
        output fmt_grant_o, out_data_o, out_chid_o, out_last_o, out_valid_o
    );
    modport master (
        output fmt_req_i, fmt_chid_i, fmt_length_i, fmt_data_i, fmt_start_i, fmt_end_i, out_ready_i,
        input  fmt_grant_o, out_data_o, out_chid_o, out_last_o, out_valid_o
    );
endinterface

// File: rtl/fmt_receiver.sv
// Grants formatter packets only when the show-ahead buffer can hold them,
// stores words with channel/last tags, and keeps per-channel completion counts.
module fmt_receiver #(
    parameter int DEPTH = 64,
    parameter int TMO   = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    fmt_receiver_if.slave bus,
    input  logic          cnt_clr_i,
    output logic [7:0]    ch0_cnt_o,
    output logic [7:0]    ch1_cnt_o,
    output logic [7:0]    ch2_cnt_o,
    output logic          len_err_o,
    output logic          tmo_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, RECV} state_t;
    state_t r_state, w_state_nx;

    logic [34:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic [1:0]      r_chid;
    logic [5:0]      r_len, r_wcnt;
    logic [TW-1:0]   r_tmo;
    logic [2:0][7:0] r_cnt;
    logic            r_len_err, r_tmo_err;

    logic [AW:0] w_free, w_len_ext;
    logic        w_full, w_empty, w_push, w_pop;
    logic        w_wr, w_done, w_tmo_hit, w_drop, w_short, w_last;

    assign w_free    = (AW+1)'(DEPTH) - r_count;
    assign w_len_ext = (AW+1)'(bus.fmt_length_i);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && bus.out_ready_i;
    assign w_push    = w_wr && (!w_full || w_pop);

    // The length-th word is tagged last on write, so an overlong packet still
    // ends cleanly in the buffer even if that word has already been popped.
    assign w_last  = bus.fmt_end_i || ({1'b0, r_wcnt} + 7'd1 == {1'b0, r_len});
    assign w_drop  = (r_state == RECV) && !(r_wcnt < r_len);
    assign w_short = w_done && ({1'b0, r_wcnt} + 7'd1 < {1'b0, r_len});

    always_ff @(posedge clk_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_wr       = 1'b0;
        w_done     = 1'b0;
        w_tmo_hit  = 1'b0;
        case (r_state)
            IDLE: if (bus.fmt_req_i && bus.fmt_length_i != 6'd0 && w_free >= w_len_ext)
                      w_state_nx = GRANT;
            GRANT: w_state_nx = WAIT;
            WAIT: begin
                if (bus.fmt_start_i) begin
                    w_wr = 1'b1;
                    if (bus.fmt_end_i) begin
                        w_done     = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = RECV;
                    end
                end else if (r_tmo == TW'(TMO - 1)) begin
                    w_tmo_hit  = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            RECV: begin
                w_wr = (r_wcnt < r_len);
                if (bus.fmt_end_i) begin
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_last, r_chid, bus.fmt_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_chid   <= '0;
            r_len    <= '0;
            r_wcnt   <= '0;
            r_tmo    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_state == IDLE && w_state_nx == GRANT) begin
                r_chid <= bus.fmt_chid_i;
                r_len  <= bus.fmt_length_i;
            end
            if (r_state == GRANT) begin
                r_wcnt <= '0;
                r_tmo  <= '0;
            end else begin
                if (w_wr)              r_wcnt <= r_wcnt + 1'b1;
                if (r_state == WAIT)   r_tmo  <= r_tmo + 1'b1;
            end
        end
    end

    // Clear has priority over any increment or error set in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || cnt_clr_i) begin
            r_cnt     <= '0;
            r_len_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++)
                if (w_done && r_chid == 2'(c) && r_cnt[c] != 8'hFF)
                    r_cnt[c] <= r_cnt[c] + 8'd1;
            if (w_drop || w_short) r_len_err <= 1'b1;
            if (w_tmo_hit)         r_tmo_err <= 1'b1;
        end
    end

    assign bus.fmt_grant_o = (r_state == GRANT);
    assign bus.out_valid_o = !w_empty;
    assign bus.out_data_o  = w_empty ? 32'd0 : r_mem[r_rd_ptr][31:0];
    assign bus.out_chid_o  = w_empty ? 2'd0  : r_mem[r_rd_ptr][33:32];
    assign bus.out_last_o  = w_empty ? 1'b0  : r_mem[r_rd_ptr][34];
    assign ch0_cnt_o = r_cnt[0];
    assign ch1_cnt_o = r_cnt[1];
    assign ch2_cnt_o = r_cnt[2];
    assign len_err_o = r_len_err;
    assign tmo_err_o = r_tmo_err;
endmodule

// File: tb/tb_fmt_receiver.sv
// Directed vector bench for fmt_receiver: packet table plus hand sequences
// for buffer-full gating, timeout, counter saturation/clear and reset.
module tb_fmt_receiver;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [7:0] c0, c1, c2;
    logic       len_err, tmo_err;

    fmt_receiver_if bus();

    fmt_receiver #(.DEPTH(64), .TMO(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus), .cnt_clr_i(cnt_clr),
        .ch0_cnt_o(c0), .ch1_cnt_o(c1), .ch2_cnt_o(c2),
        .len_err_o(len_err), .tmo_err_o(tmo_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_data[$];
    logic [1:0]  q_chid[$];
    logic        q_last[$];

    typedef struct {
        logic [1:0] ch;
        logic [5:0] len;
        int         nw;
        int         exp_st;
        logic       exp_le;
        logic [7:0] exp_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.fmt_req_i    = 1'b0;
        bus.fmt_chid_i   = 2'd0;
        bus.fmt_length_i = 6'd0;
        bus.fmt_data_i   = 32'd0;
        bus.fmt_start_i  = 1'b0;
        bus.fmt_end_i    = 1'b0;
    endtask

    // Returns at the negedge where the grant is seen.
    task automatic req_grant(input logic [1:0] ch, input logic [5:0] len);
        bit ok = 1'b0;
        @(negedge clk);
        bus.fmt_req_i = 1'b1; bus.fmt_chid_i = ch; bus.fmt_length_i = len;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.fmt_grant_o) ok = 1'b1;
        end
        bus.fmt_req_i = 1'b0;
        chk("grant_seen", 32'(ok), 32'd1);
    endtask

    task automatic send_words(input int n, input logic [31:0] base);
        @(negedge clk);
        chk("grant_one_cycle", 32'(bus.fmt_grant_o), 32'd0);
        for (int w = 0; w < n; w++) begin
            bus.fmt_start_i = (w == 0);
            bus.fmt_end_i   = (w == n - 1);
            bus.fmt_data_i  = base + 32'(w);
            @(negedge clk);
        end
        bus.fmt_start_i = 1'b0; bus.fmt_end_i = 1'b0;
    endtask

    task automatic drain();
        q_data.delete(); q_chid.delete(); q_last.delete();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!bus.out_valid_o) break;
            q_data.push_back(bus.out_data_o);
            q_chid.push_back(bus.out_chid_o);
            q_last.push_back(bus.out_last_o);
            @(negedge clk);
        end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        bit          got;
        logic [31:0] base;
        vecs[0] = '{2'd1, 6'd4,  4,  4,  1'b0, 8'd1};
        vecs[1] = '{2'd0, 6'd4,  6,  4,  1'b1, 8'd1};
        vecs[2] = '{2'd2, 6'd5,  3,  3,  1'b1, 8'd1};
        vecs[3] = '{2'd3, 6'd3,  3,  3,  1'b0, 8'd0};
        vecs[4] = '{2'd1, 6'd1,  1,  1,  1'b0, 8'd1};
        vecs[5] = '{2'd2, 6'd63, 63, 63, 1'b0, 8'd1};
        vecs[6] = '{2'd0, 6'd2,  3,  2,  1'b1, 8'd1};

        idle_in();
        bus.out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_grant", 32'(bus.fmt_grant_o), 32'd0);
        chk("rst_data",  bus.out_data_o, 32'd0);
        chk("rst_cnt",   {8'd0, c0, c1, c2}, 32'd0);
        chk("rst_err",   {30'd0, len_err, tmo_err}, 32'd0);
        rstn = 1'b1;

        for (int v = 0; v < 7; v++) begin
            clr_pulse();
            base = 32'hA000_0000 | (32'(v) << 8);
            req_grant(vecs[v].ch, vecs[v].len);
            send_words(vecs[v].nw, base);
            drain();
            chk($sformatf("v%0d_nwords", v), 32'(q_data.size()), 32'(vecs[v].exp_st));
            for (int k = 0; k < q_data.size() && k < vecs[v].exp_st; k++) begin
                chk($sformatf("v%0d_data%0d", v, k), q_data[k], base + 32'(k));
                chk($sformatf("v%0d_chid%0d", v, k), 32'(q_chid[k]), 32'(vecs[v].ch));
                chk($sformatf("v%0d_last%0d", v, k), 32'(q_last[k]), 32'(k == vecs[v].exp_st - 1));
            end
            chk($sformatf("v%0d_len_err", v), 32'(len_err), 32'(vecs[v].exp_le));
            chk($sformatf("v%0d_ch0", v), 32'(c0), (vecs[v].ch == 2'd0) ? 32'(vecs[v].exp_cnt) : 32'd0);
            chk($sformatf("v%0d_ch1", v), 32'(c1), (vecs[v].ch == 2'd1) ? 32'(vecs[v].exp_cnt) : 32'd0);
            chk($sformatf("v%0d_ch2", v), 32'(c2), (vecs[v].ch == 2'd2) ? 32'(vecs[v].exp_cnt) : 32'd0);
        end

        // Buffer nearly full: 62 held, a 4-word request waits until two pops.
        clr_pulse();
        req_grant(2'd0, 6'd62);
        send_words(62, 32'hB000_0000);
        bus.fmt_req_i = 1'b1; bus.fmt_chid_i = 2'd1; bus.fmt_length_i = 6'd4;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.fmt_grant_o) got = 1'b1;
        end
        chk("full_no_grant", 32'(got), 32'd0);
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.fmt_grant_o) got = 1'b1;
            else @(negedge clk);
        end
        bus.fmt_req_i = 1'b0;
        chk("full_grant_after_drain", 32'(got), 32'd1);
        send_words(4, 32'hC000_0000);
        drain();
        chk("full_nwords", 32'(q_data.size()), 32'd64);
        if (q_data.size() == 64) begin
            chk("full_first",   q_data[0], 32'hB000_0002);
            chk("full_p1_last", 32'(q_last[59]), 32'd1);
            chk("full_p2_data", q_data[60], 32'hC000_0000);
            chk("full_p2_chid", 32'(q_chid[63]), 32'd1);
            chk("full_p2_last", 32'(q_last[63]), 32'd1);
        end

        // ch0 saturation, then clear wipes counters and error flags.
        clr_pulse();
        bus.out_ready_i = 1'b1;
        for (int p = 0; p < 255; p++) begin
            req_grant(2'd0, 6'd1);
            send_words(1, 32'(p));
        end
        chk("sat_255", 32'(c0), 32'd255);
        req_grant(2'd0, 6'd1);
        send_words(1, 32'hFFFF);
        chk("sat_hold", 32'(c0), 32'd255);
        req_grant(2'd1, 6'd2);
        send_words(1, 32'h1234);
        chk("sat_len_err", 32'(len_err), 32'd1);
        clr_pulse();
        chk("clr_ch0",     32'(c0), 32'd0);
        chk("clr_ch1",     32'(c1), 32'd0);
        chk("clr_len_err", 32'(len_err), 32'd0);
        drain();

        // Timeout: 16 WAIT cycles without start.
        req_grant(2'd2, 6'd3);
        repeat (16) @(negedge clk);
        chk("tmo_not_yet", 32'(tmo_err), 32'd0);
        @(negedge clk);
        chk("tmo_set",    32'(tmo_err), 32'd1);
        chk("tmo_buffer", 32'(bus.out_valid_o), 32'd0);
        req_grant(2'd2, 6'd3);
        send_words(3, 32'hD000_0000);
        drain();
        chk("tmo_after_nwords", 32'(q_data.size()), 32'd3);
        chk("tmo_after_ch2",    32'(c2), 32'd1);

        // Reset in the middle of a packet.
        req_grant(2'd1, 6'd8);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            bus.fmt_start_i = (w == 0);
            bus.fmt_data_i  = 32'hE000_0000 + 32'(w);
            @(negedge clk);
        end
        bus.fmt_start_i = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_rst_grant", 32'(bus.fmt_grant_o), 32'd0);
        chk("mid_rst_cnt",   {8'd0, c0, c1, c2}, 32'd0);
        chk("mid_rst_err",   {30'd0, len_err, tmo_err}, 32'd0);
        rstn = 1'b1;
        idle_in();
        req_grant(2'd1, 6'd2);
        send_words(2, 32'hF000_0000);
        drain();
        chk("post_rst_nwords", 32'(q_data.size()), 32'd2);
        chk("post_rst_ch1",    32'(c1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmt_receiver.md
FMT_RECEIVER -- requirements
Module: fmt_receiver

Interface
REQ-001 Parameter DEPTH, default 64, internal buffer depth in words, power of two, ≥32.
REQ-002 Parameter TMO, default 16, cycles from grant to start before timeout.
REQ-003 clk_i  input  1  single clock, rising edge.
REQ-004 rstn_i  input  1  reset, synchronous, active-low.
REQ-005 fmt_req_i  input  1  formatter packet-ready request.
REQ-006 fmt_grant_o  output  1  one-cycle grant to formatter.
REQ-007 fmt_chid_i  input  2  channel id of offered packet.
REQ-008 fmt_length_i  input  6  word count of offered packet.
REQ-009 fmt_data_i  input  32  packet word.
REQ-010 fmt_start_i  input  1  marks first word.
REQ-011 fmt_end_i  input  1  marks last word.
REQ-012 out_data_o  output  32  buffered word.
REQ-013 out_chid_o  output  2  channel id of out_data_o.
REQ-014 out_last_o  output  1  out_data_o is last word of its packet.
REQ-015 out_valid_o  output  1  out_* holds a word.
REQ-016 out_ready_i  input  1  downstream accepts word.
REQ-017 cnt_clr_i  input  1  clears counters and error flags.
REQ-018 ch0_cnt_o, ch1_cnt_o, ch2_cnt_o  output  8 each  completed-packet counters.
REQ-019 len_err_o  output  1  sticky: length mismatch seen.
REQ-020 tmo_err_o  output  1  sticky: start timeout seen.

Function
REQ-021 FSM states IDLE, GRANT, WAIT, RECV; exactly one active.
REQ-022 IDLE->GRANT when fmt_req_i=1, fmt_length_i≠0, free≥fmt_length_i; latch chid and length that cycle; otherwise stay IDLE.
REQ-023 GRANT: fmt_grant_o=1 for exactly that one cycle; next state WAIT; fmt_grant_o=0 in all other states.
REQ-024 WAIT: fmt_start_i=1 -> write word, word count=1, go RECV (or IDLE if fmt_end_i=1 same cycle); TMO cycles without start -> tmo_err_o=1, IDLE.
REQ-025 RECV: every cycle writes fmt_data_i with latched chid; fmt_end_i=1 writes word with last=1 and returns to IDLE.
REQ-026 Words beyond latched length are dropped and set len_err_o; end with count<length sets len_err_o; end word written with last=1 in both cases unless dropped, then last word kept in buffer gets last=1 forced.
REQ-027 Packet completion increments counter for latched chid, saturating at 255; chid=3 increments none.
REQ-028 Buffer show-ahead FIFO: out_valid_o=!empty; pop on out_valid_o&out_ready_i; simultaneous push and pop allowed at full or empty.
REQ-029 free = DEPTH minus occupancy, computed with one extra bit; no write ever occurs when full.
REQ-030 Grant reservation guarantees no overflow; fmt_req_i deasserting in GRANT/WAIT does not abort.
REQ-031 cnt_clr_i=1 zeroes counters and both error flags next cycle; simultaneous increment loses to clear; FSM and buffer unaffected.
REQ-032 No combinational path from fmt_*_i to fmt_grant_o.

Reset
REQ-033 rstn_i=0 at edge: FSM IDLE, buffer empty, counters 0, all outputs 0, mid-packet data discarded.
REQ-034 First grant possible on second edge after rstn_i returns to 1.

Verification
REQ-035 req, chid=1, len=4, start+4 words after grant -> grant 1 cycle, out yields 4 words chid=1, last on 4th, ch1_cnt_o=1.
REQ-036 DEPTH=64, 62 words held, out_ready_i=0, req len=4 -> no grant; drain 2 -> grant.
REQ-037 Grant, no start for 16 cycles -> tmo_err_o=1, IDLE, buffer unchanged.
REQ-038 len=4, end on 6th word -> 4 words stored, 4th last=1, len_err_o=1.
REQ-039 ch0 counter at 255, one more packet -> stays 255; cnt_clr_i -> 0.
REQ-040 rstn_i=0 mid-RECV -> next cycle out_valid_o=0, counters 0, fmt_grant_o=0.
